// File: rtl/count_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : count_sampler
// Description : Captures snapshots of an upstream free-running counter into a
//               first-word-fall-through FIFO on each capture event.
//               Each entry is {wrap, count}. The wrap bit records whether the
//               counter rolled over since the previous accepted sample.
//               A wrap seen while a capture is dropped is carried to the next
//               accepted sample.
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous active-low reset
//               count    - upstream counter value [WIDTH-1:0]
//               trig     - capture request
//               m_valid  - FIFO head valid
//               m_ready  - consumer accepts head
//               m_data   - {wrap, count_sample} [WIDTH:0], 0 when empty
//               level    - occupancy [$clog2(DEPTH):0]
//               overflow - sticky, a capture was dropped
//               clr_ovf  - clears overflow (a same-cycle drop wins)
// Config      : COUNT_SAMPLER_LEVEL_TRIG_EN defined -> every cycle with
//               trig=1 is a capture. Undefined (default) -> rising edge of trig.
// Revision    : 1.0 - initial release
// ============================================================================
module count_sampler #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [WIDTH-1:0]          count,
   input  logic                      trig,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [WIDTH:0]            m_data,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      overflow,
   input  logic                      clr_ovf
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_count_q;
   logic             r_wrap_pend;
   logic             r_overflow;
   // One bit wider than the index so that full and empty are distinguishable.
   logic [AW:0]      r_rd_ptr;
   logic [AW:0]      r_wr_ptr;
   logic [WIDTH:0]   r_mem [DEPTH];

   logic             w_wrap_now;
   logic             w_cap;
   logic [AW:0]      w_level;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;

`ifdef COUNT_SAMPLER_LEVEL_TRIG_EN
   assign w_cap = trig;
`else
   logic r_trig_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_trig_q <= 1'b0;
      end else begin
         r_trig_q <= trig;
      end
   end

   assign w_cap = trig & ~r_trig_q;
`endif

   assign w_wrap_now = (r_count_q == '1) && (count == '0);

   assign w_level = r_wr_ptr - r_rd_ptr;
   assign w_full  = (w_level == C_DEPTH);
   assign m_valid = (w_level != '0);
   assign level   = w_level;

   // A pop frees a slot in the same cycle, so a capture on a full FIFO is
   // accepted when the consumer takes the head at that edge.
   assign w_pop  = m_valid & m_ready;
   assign w_push = w_cap & (~w_full | w_pop);
   assign w_drop = w_cap & w_full & ~w_pop;

   assign m_data   = m_valid ? r_mem[r_rd_ptr[AW-1:0]] : '0;
   assign overflow = r_overflow;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count_q   <= '0;
         r_wrap_pend <= 1'b0;
         r_overflow  <= 1'b0;
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
      end else begin
         r_count_q <= count;

         if (w_push) begin
            r_wr_ptr    <= r_wr_ptr + 1'b1;
            r_wrap_pend <= 1'b0;
         end else begin
            r_wrap_pend <= r_wrap_pend | w_wrap_now;
         end

         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end

         // Set has priority over clear.
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (clr_ovf) begin
            r_overflow <= 1'b0;
         end
      end
   end

   // Storage needs no reset: reset empties the FIFO through the pointers and
   // m_data is forced to zero while empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {r_wrap_pend | w_wrap_now, count};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_count_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_count_sampler
// Description : Self-checking bench for count_sampler. A queue-based model of
//               the sampler predicts FIFO contents, wrap tagging and overflow.
//               Honours COUNT_SAMPLER_LEVEL_TRIG_EN for the capture rule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_sampler;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] count = 8'h00;
   logic       trig = 1'b0;
   logic       m_ready = 1'b0;
   logic       clr_ovf = 1'b0;
   logic       m_valid;
   logic [8:0] m_data;
   logic [3:0] level;
   logic       overflow;

   int n_tests = 0;
   int n_fail  = 0;

   count_sampler #(.WIDTH(8), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .count    (count),
      .trig     (trig),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .level    (level),
      .overflow (overflow),
      .clr_ovf  (clr_ovf)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [8:0] mq[$];
   bit         m_wpend;
   bit         m_ovf;
   bit         m_prev_trig;
   logic [7:0] m_prev_count;

   function automatic void model_update();
      bit wrap, cap, full, pop;
      if (!rst) begin
         mq.delete();
         m_wpend = 0; m_ovf = 0; m_prev_trig = 0; m_prev_count = 8'h00;
         return;
      end
      wrap = (m_prev_count == 8'hFF) && (count == 8'h00);
`ifdef COUNT_SAMPLER_LEVEL_TRIG_EN
      cap = trig;
`else
      cap = trig && !m_prev_trig;
`endif
      full = (mq.size() == DEPTH);
      pop  = (mq.size() != 0) && m_ready;
      if (pop) void'(mq.pop_front());
      if (cap && (!full || pop)) begin
         mq.push_back({m_wpend | wrap, count});
         m_wpend = 0;
      end else begin
         m_wpend = m_wpend | wrap;
      end
      if (cap && full && !pop) m_ovf = 1;
      else if (clr_ovf)        m_ovf = 0;
      m_prev_count = count;
      m_prev_trig  = trig;
   endfunction

   function automatic logic [8:0] exp_head();
      return (mq.size() != 0) ? mq[0] : 9'h000;
   endfunction

   // Advance one clock; inputs are applied 1 ns after an edge and outputs
   // are observed 1 ns after the next edge.
   task automatic step();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [7:0] c);
      count = c; trig = 1'b1; step();
      trig = 1'b0; step();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         trig  = i[0];
         count = 8'($urandom);
         step();
         n_tests += 4;
         if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", m_valid); end
         if (level !== 4'd0)   begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
         if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
         if (m_data !== 9'h000) begin n_fail++; $display("FAIL reset_data: got %h want 000", m_data); end
      end
      trig = 1'b0; count = 8'h00; rst = 1'b1;
      step();
   endtask

   task automatic test_single();
      m_ready = 1'b0;
      count = 8'h2A; trig = 1'b1; step();
      trig = 1'b0;
      n_tests += 3;
      if (m_valid !== 1'b1)  begin n_fail++; $display("FAIL single_valid: got %b want 1", m_valid); end
      if (m_data !== 9'h02A) begin n_fail++; $display("FAIL single_data: got %h want 02a", m_data); end
      if (level !== 4'd1)    begin n_fail++; $display("FAIL single_level: got %0d want 1", level); end
      m_ready = 1'b1; step(); m_ready = 1'b0;
      n_tests += 2;
      if (m_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid: got %b want 0", m_valid); end
      if (level !== 4'd0)   begin n_fail++; $display("FAIL single_pop_level: got %0d want 0", level); end
   endtask

   task automatic test_wrap();
      logic [8:0] exp_w [3];
      exp_w[0] = 9'h0F0; exp_w[1] = 9'h105; exp_w[2] = 9'h010;
      m_ready = 1'b0;
      pulse(8'hF0);
      count = 8'hFF; step();
      count = 8'h00; step();
      pulse(8'h05);
      pulse(8'h10);
      n_tests++;
      if (level !== 4'd3) begin n_fail++; $display("FAIL wrap_level: got %0d want 3", level); end
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (m_data !== exp_w[i]) begin n_fail++; $display("FAIL wrap_entry%0d: got %h want %h", i, m_data, exp_w[i]); end
         step();
      end
      m_ready = 1'b0;
      n_tests++;
      if (m_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_empty: got %b want 0", m_valid); end
   endtask

   task automatic test_full_overflow();
      logic [8:0] exp_f [8];
      exp_f[0] = 9'h042; exp_f[1] = 9'h043; exp_f[2] = 9'h044; exp_f[3] = 9'h045;
      exp_f[4] = 9'h046; exp_f[5] = 9'h047; exp_f[6] = 9'h050; exp_f[7] = 9'h103;
      m_ready = 1'b0;
      for (int i = 0; i < 9; i++) pulse(8'h40 + 8'(i));
      n_tests += 3;
      if (level !== 4'd8)    begin n_fail++; $display("FAIL full_level: got %0d want 8", level); end
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_ovf: got %b want 1", overflow); end
      if (m_data !== 9'h040) begin n_fail++; $display("FAIL full_head: got %h want 040", m_data); end
      // capture while full with a same-cycle pop
      count = 8'h50; trig = 1'b1; m_ready = 1'b1; step();
      trig = 1'b0; m_ready = 1'b0;
      n_tests += 2;
      if (level !== 4'd8)    begin n_fail++; $display("FAIL pushpop_level: got %0d want 8", level); end
      if (m_data !== 9'h041) begin n_fail++; $display("FAIL pushpop_head: got %h want 041", m_data); end
      clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
      n_tests++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_ovf: got %b want 0", overflow); end
      // drop coinciding with clear: set wins
      count = 8'h51; trig = 1'b1; clr_ovf = 1'b1; step();
      trig = 1'b0; clr_ovf = 1'b0;
      n_tests++;
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
      // wrap on the very cycle of a dropped capture
      count = 8'hFF; step();
      count = 8'h00; trig = 1'b1; step();
      trig = 1'b0; step();
      m_ready = 1'b1; step(); m_ready = 1'b0;
      n_tests++;
      if (level !== 4'd7) begin n_fail++; $display("FAIL drain_one_level: got %0d want 7", level); end
      pulse(8'h03);
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (m_data !== exp_f[i]) begin n_fail++; $display("FAIL full_entry%0d: got %h want %h", i, m_data, exp_f[i]); end
         step();
      end
      m_ready = 1'b0;
      clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
      n_tests += 2;
      if (m_valid !== 1'b0)  begin n_fail++; $display("FAIL full_drained: got %b want 0", m_valid); end
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_clr: got %b want 0", overflow); end
   endtask

   task automatic test_held_trigger();
      logic [3:0] exp_lvl;
      logic       exp_ovf;
`ifdef COUNT_SAMPLER_LEVEL_TRIG_EN
      exp_lvl = 4'd8; exp_ovf = 1'b1;
`else
      exp_lvl = 4'd1; exp_ovf = 1'b0;
`endif
      m_ready = 1'b0;
      trig = 1'b1;
      for (int i = 0; i < 10; i++) begin
         count = 8'h60 + 8'(i);
         step();
      end
      trig = 1'b0;
      n_tests += 3;
      if (level !== exp_lvl)    begin n_fail++; $display("FAIL held_level: got %0d want %0d", level, exp_lvl); end
      if (overflow !== exp_ovf) begin n_fail++; $display("FAIL held_ovf: got %b want %b", overflow, exp_ovf); end
      if (m_data !== 9'h060)    begin n_fail++; $display("FAIL held_head: got %h want 060", m_data); end
      m_ready = 1'b1; clr_ovf = 1'b1;
      repeat (DEPTH) step();
      m_ready = 1'b0; clr_ovf = 1'b0;
      n_tests++;
      if (m_valid !== 1'b0) begin n_fail++; $display("FAIL held_drain: got %b want 0", m_valid); end
   endtask

   task automatic test_async_reset();
      m_ready = 1'b0;
      for (int i = 0; i < 9; i++) pulse(8'h70 + 8'(i));
      n_tests++;
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL pre_reset_ovf: got %b want 1", overflow); end
      #2;
      rst = 1'b0;
      #1;
      n_tests += 4;
      if (m_valid !== 1'b0)  begin n_fail++; $display("FAIL async_valid: got %b want 0", m_valid); end
      if (level !== 4'd0)    begin n_fail++; $display("FAIL async_level: got %0d want 0", level); end
      if (m_data !== 9'h000) begin n_fail++; $display("FAIL async_data: got %h want 000", m_data); end
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL async_ovf: got %b want 0", overflow); end
      step();
      count = 8'h00; rst = 1'b1;
      step();
   endtask

   task automatic test_back_to_back();
      m_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         count = 8'h80 + 8'(i);
         trig  = ~trig;
         step();
         n_tests += 2;
         if (level !== 4'(mq.size())) begin n_fail++; $display("FAIL b2b_level: got %0d want %0d", level, mq.size()); end
         if (m_data !== exp_head())   begin n_fail++; $display("FAIL b2b_data: got %h want %h", m_data, exp_head()); end
      end
      trig = 1'b0; m_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [7:0] c;
      c = 8'hF8;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) c = 8'hFD;
         else if ($urandom_range(0, 29) == 0) c = 8'h00;
         else c = c + 8'd1;
         count   = c;
         trig    = ($urandom_range(0, 2) != 0);
         m_ready = ($urandom_range(0, 3) == 0) ? 1'b1 : (($urandom_range(0, 1) == 0) && (i > 1500));
         clr_ovf = ($urandom_range(0, 15) == 0);
         step();
         n_tests += 4;
         if (m_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid @%0d: got %b want %b", i, m_valid, mq.size() != 0); end
         if (level !== 4'(mq.size()))      begin n_fail++; $display("FAIL rnd_level @%0d: got %0d want %0d", i, level, mq.size()); end
         if (m_data !== exp_head())        begin n_fail++; $display("FAIL rnd_data @%0d: got %h want %h", i, m_data, exp_head()); end
         if (overflow !== m_ovf)           begin n_fail++; $display("FAIL rnd_ovf @%0d: got %b want %b", i, overflow, m_ovf); end
      end
      trig = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0;
   endtask

   initial begin
      #1;
      test_reset();
      test_single();
      test_wrap();
      test_full_overflow();
      test_held_trigger();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
